csr_exec: RTL and testbench

- Execute-side sequencer for SYSTEM instructions: CSR read-modify-write ops (csrrw/s/c and immediate forms), ecall and mret.
- Sits directly upstream of the CSR file. Drives its address, write-enable, write data, ecall strobe and pc. Consumes its read data, mtvec and mepc.
- Returns the old CSR value for rd writeback, plus a pc redirect for ecall/mret, to the downstream stage over a valid/ready handshake.

---
 rtl/csr_exec.sv | 138 +++++++++++++
 tb/tb_csr_exec.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/csr_exec.sv
// Execute-side sequencer for SYSTEM instructions: CSR read-modify-write, ecall and mret.
// Three-state flow IDLE -> EXEC -> RESP; the CSR file is read and written during EXEC.
module csr_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic             in_is_ecall,
    input  logic             in_is_mret,
    input  logic [11:0]      in_csr_addr,
    input  logic [4:0]       in_rs1_idx,
    input  logic [WIDTH-1:0] in_rs1_data,
    input  logic [4:0]       in_rd_idx,
    input  logic [WIDTH-1:0] in_pc,
    output logic [11:0]      csr_addr,
    output logic             csr_wen,
    output logic [WIDTH-1:0] csr_wdata,
    output logic             csr_is_ecall,
    output logic [WIDTH-1:0] csr_pc,
    input  logic [WIDTH-1:0] csr_rdata,
    input  logic [WIDTH-1:0] csr_mtvec,
    input  logic [WIDTH-1:0] csr_mepc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_rd_idx,
    output logic [WIDTH-1:0] out_rd_data,
    output logic             out_rd_wen,
    output logic             out_redirect,
    output logic [WIDTH-1:0] out_redirect_pc,
    output logic             out_illegal
);

    // Handshakes: a transfer happens on a clock edge where valid and ready are both high.
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    logic [2:0]       f3_q;
    logic             ecall_q;
    logic             mret_q;
    logic [4:0]       rs1_idx_q;
    logic [4:0]       rd_idx_q;
    logic [WIDTH-1:0] rs1_data_q;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] wdata_calc;
    logic             in_is_op;
    logic             in_wen_dec;
    logic             q_is_op;

    assign in_ready = (state == IDLE);

    // Decode of the incoming instruction so csr_wen can be a registered strobe in EXEC.
    assign in_is_op   = !in_is_ecall && !in_is_mret && (in_funct3[1:0] != 2'b00);
    assign in_wen_dec = in_is_op && ((in_funct3[1:0] == 2'b01) || (in_rs1_idx != 5'd0));
    assign q_is_op    = !ecall_q && !mret_q && (f3_q[1:0] != 2'b00);

    always_comb begin
        operand    = f3_q[2] ? {{(WIDTH-5){1'b0}}, rs1_idx_q} : rs1_data_q;
        wdata_calc = '0;
        case (f3_q[1:0])
            2'b01:   wdata_calc = operand;
            2'b10:   wdata_calc = csr_rdata | operand;
            2'b11:   wdata_calc = csr_rdata & ~operand;
            default: wdata_calc = '0;
        endcase
    end

    // Write data depends on the old value read this cycle, so it cannot be registered.
    assign csr_wdata = (state == EXEC) ? wdata_calc : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            f3_q            <= '0;
            ecall_q         <= 1'b0;
            mret_q          <= 1'b0;
            rs1_idx_q       <= '0;
            rd_idx_q        <= '0;
            rs1_data_q      <= '0;
            csr_addr        <= '0;
            csr_wen         <= 1'b0;
            csr_is_ecall    <= 1'b0;
            csr_pc          <= '0;
            out_valid       <= 1'b0;
            out_rd_idx      <= '0;
            out_rd_data     <= '0;
            out_rd_wen      <= 1'b0;
            out_redirect    <= 1'b0;
            out_redirect_pc <= '0;
            out_illegal     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        f3_q         <= in_funct3;
                        ecall_q      <= in_is_ecall;
                        mret_q       <= in_is_mret && !in_is_ecall;
                        rs1_idx_q    <= in_rs1_idx;
                        rd_idx_q     <= in_rd_idx;
                        rs1_data_q   <= in_rs1_data;
                        csr_addr     <= in_csr_addr;
                        csr_pc       <= in_pc;
                        csr_wen      <= in_wen_dec;
                        csr_is_ecall <= in_is_ecall;
                        state        <= EXEC;
                    end
                end
                EXEC: begin
                    csr_wen      <= 1'b0;
                    csr_is_ecall <= 1'b0;
                    out_valid    <= 1'b1;
                    out_rd_idx   <= rd_idx_q;
                    out_rd_data  <= csr_rdata;
                    out_rd_wen   <= q_is_op && (rd_idx_q != 5'd0);
                    out_redirect <= ecall_q || mret_q;
                    out_illegal  <= !ecall_q && !mret_q && (f3_q[1:0] == 2'b00);
                    if (ecall_q)
                        out_redirect_pc <= csr_mtvec;
                    else if (mret_q)
                        out_redirect_pc <= csr_mepc;
                    else
                        out_redirect_pc <= '0;
                    state <= RESP;
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_exec.sv
// Directed bench for csr_exec: CSR ops, ecall/mret redirects, output stall and reset mid-operation.
module tb_csr_exec;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic        in_is_ecall;
    logic        in_is_mret;
    logic [11:0] in_csr_addr;
    logic [4:0]  in_rs1_idx;
    logic [31:0] in_rs1_data;
    logic [4:0]  in_rd_idx;
    logic [31:0] in_pc;
    logic [11:0] csr_addr;
    logic        csr_wen;
    logic [31:0] csr_wdata;
    logic        csr_is_ecall;
    logic [31:0] csr_pc;
    logic [31:0] csr_rdata;
    logic [31:0] csr_mtvec;
    logic [31:0] csr_mepc;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd_idx;
    logic [31:0] out_rd_data;
    logic        out_rd_wen;
    logic        out_redirect;
    logic [31:0] out_redirect_pc;
    logic        out_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    csr_exec #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
        .in_is_ecall(in_is_ecall), .in_is_mret(in_is_mret), .in_csr_addr(in_csr_addr),
        .in_rs1_idx(in_rs1_idx), .in_rs1_data(in_rs1_data), .in_rd_idx(in_rd_idx), .in_pc(in_pc),
        .csr_addr(csr_addr), .csr_wen(csr_wen), .csr_wdata(csr_wdata),
        .csr_is_ecall(csr_is_ecall), .csr_pc(csr_pc), .csr_rdata(csr_rdata),
        .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd_idx(out_rd_idx),
        .out_rd_data(out_rd_data), .out_rd_wen(out_rd_wen), .out_redirect(out_redirect),
        .out_redirect_pc(out_redirect_pc), .out_illegal(out_illegal)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: called at a negedge in IDLE; returns at the negedge of the EXEC cycle.
    task automatic send(input logic [2:0] f3, input logic ec, input logic mr,
                        input logic [11:0] addr, input logic [4:0] rs1i,
                        input logic [31:0] rs1d, input logic [4:0] rd, input logic [31:0] pc);
        int waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: in_ready=%0b want 1", in_ready);
        end
        in_funct3 = f3; in_is_ecall = ec; in_is_mret = mr; in_csr_addr = addr;
        in_rs1_idx = rs1i; in_rs1_data = rs1d; in_rd_idx = rd; in_pc = pc;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
        n_checks++; if (csr_wen !== 1'b0) begin n_fail++; $display("FAIL rst_csr_wen: got %0b want 0", csr_wen); end
        n_checks++; if (out_rd_data !== 32'h0) begin n_fail++; $display("FAIL rst_rd_data: got %h want 0", out_rd_data); end
        n_checks++; if (csr_addr !== 12'h0) begin n_fail++; $display("FAIL rst_csr_addr: got %h want 0", csr_addr); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_csrrw();
        csr_rdata = 32'h0;
        send(3'b001, 1'b0, 1'b0, 12'h305, 5'd7, 32'h8000_0100, 5'd5, 32'h0);
        n_checks++; if (csr_wen !== 1'b1) begin n_fail++; $display("FAIL rw_wen: got %0b want 1", csr_wen); end
        n_checks++; if (csr_wdata !== 32'h8000_0100) begin n_fail++; $display("FAIL rw_wdata: got %h want 80000100", csr_wdata); end
        n_checks++; if (csr_addr !== 12'h305) begin n_fail++; $display("FAIL rw_addr: got %h want 305", csr_addr); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rw_in_ready_exec: got %0b want 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rw_valid_early: got %0b want 0", out_valid); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rw_valid_latency: got %0b want 1", out_valid); end
        n_checks++; if (csr_wen !== 1'b0) begin n_fail++; $display("FAIL rw_wen_resp: got %0b want 0", csr_wen); end
        n_checks++; if (out_rd_data !== 32'h0) begin n_fail++; $display("FAIL rw_rd_data: got %h want 0", out_rd_data); end
        n_checks++; if (out_rd_wen !== 1'b1) begin n_fail++; $display("FAIL rw_rd_wen: got %0b want 1", out_rd_wen); end
        n_checks++; if (out_rd_idx !== 5'd5) begin n_fail++; $display("FAIL rw_rd_idx: got %0d want 5", out_rd_idx); end
        n_checks++; if (out_redirect !== 1'b0) begin n_fail++; $display("FAIL rw_redirect: got %0b want 0", out_redirect); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rw_valid_drop: got %0b want 0", out_valid); end
    endtask

    task automatic test_csrrs();
        csr_rdata = 32'h1800;
        send(3'b010, 1'b0, 1'b0, 12'h300, 5'd0, 32'hFFFF_FFFF, 5'd2, 32'h0);
        n_checks++; if (csr_wen !== 1'b0) begin n_fail++; $display("FAIL rs0_wen: got %0b want 0", csr_wen); end
        @(negedge clk);
        n_checks++; if (out_rd_data !== 32'h1800) begin n_fail++; $display("FAIL rs0_rd_data: got %h want 1800", out_rd_data); end
        @(negedge clk);
        send(3'b010, 1'b0, 1'b0, 12'h300, 5'd3, 32'h8, 5'd2, 32'h0);
        n_checks++; if (csr_wen !== 1'b1) begin n_fail++; $display("FAIL rs3_wen: got %0b want 1", csr_wen); end
        n_checks++; if (csr_wdata !== 32'h1808) begin n_fail++; $display("FAIL rs3_wdata: got %h want 1808", csr_wdata); end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_imm();
        csr_rdata = 32'hFFFF_FFFF;
        send(3'b111, 1'b0, 1'b0, 12'h344, 5'h1F, 32'h0, 5'd0, 32'h0);
        n_checks++; if (csr_wen !== 1'b1) begin n_fail++; $display("FAIL rci_wen: got %0b want 1", csr_wen); end
        n_checks++; if (csr_wdata !== 32'hFFFF_FFE0) begin n_fail++; $display("FAIL rci_wdata: got %h want ffffffe0", csr_wdata); end
        @(negedge clk);
        n_checks++; if (out_rd_wen !== 1'b0) begin n_fail++; $display("FAIL rci_rd_wen_x0: got %0b want 0", out_rd_wen); end
        @(negedge clk);
        csr_rdata = 32'h1234_5678;
        send(3'b101, 1'b0, 1'b0, 12'h340, 5'd0, 32'hDEAD_BEEF, 5'd1, 32'h0);
        n_checks++; if (csr_wen !== 1'b1) begin n_fail++; $display("FAIL rwi_wen: got %0b want 1", csr_wen); end
        n_checks++; if (csr_wdata !== 32'h0) begin n_fail++; $display("FAIL rwi_wdata: got %h want 0", csr_wdata); end
        @(negedge clk);
        n_checks++; if (out_rd_data !== 32'h1234_5678) begin n_fail++; $display("FAIL rwi_rd_data: got %h want 12345678", out_rd_data); end
        @(negedge clk);
    endtask

    task automatic test_ecall_mret();
        csr_rdata = 32'h0; csr_mtvec = 32'h8000_1000; csr_mepc = 32'h8000_0040;
        send(3'b000, 1'b1, 1'b0, 12'h000, 5'd0, 32'h0, 5'd0, 32'h8000_0040);
        n_checks++; if (csr_is_ecall !== 1'b1) begin n_fail++; $display("FAIL ec_strobe: got %0b want 1", csr_is_ecall); end
        n_checks++; if (csr_pc !== 32'h8000_0040) begin n_fail++; $display("FAIL ec_pc: got %h want 80000040", csr_pc); end
        n_checks++; if (csr_wen !== 1'b0) begin n_fail++; $display("FAIL ec_wen: got %0b want 0", csr_wen); end
        @(negedge clk);
        n_checks++; if (csr_is_ecall !== 1'b0) begin n_fail++; $display("FAIL ec_strobe_len: got %0b want 0", csr_is_ecall); end
        n_checks++; if (out_redirect !== 1'b1) begin n_fail++; $display("FAIL ec_redirect: got %0b want 1", out_redirect); end
        n_checks++; if (out_redirect_pc !== 32'h8000_1000) begin n_fail++; $display("FAIL ec_redirect_pc: got %h want 80001000", out_redirect_pc); end
        n_checks++; if (out_rd_wen !== 1'b0) begin n_fail++; $display("FAIL ec_rd_wen: got %0b want 0", out_rd_wen); end
        @(negedge clk);
        send(3'b000, 1'b0, 1'b1, 12'h000, 5'd0, 32'h0, 5'd0, 32'h0);
        n_checks++; if (csr_wen !== 1'b0 || csr_is_ecall !== 1'b0) begin n_fail++; $display("FAIL mret_strobes: wen=%0b ecall=%0b want 0 0", csr_wen, csr_is_ecall); end
        @(negedge clk);
        n_checks++; if (out_redirect !== 1'b1) begin n_fail++; $display("FAIL mret_redirect: got %0b want 1", out_redirect); end
        n_checks++; if (out_redirect_pc !== 32'h8000_0040) begin n_fail++; $display("FAIL mret_redirect_pc: got %h want 80000040", out_redirect_pc); end
        @(negedge clk);
    endtask

    task automatic test_stall();
        csr_rdata = 32'hA5A5_0001;
        out_ready = 1'b0;
        send(3'b001, 1'b0, 1'b0, 12'h340, 5'd4, 32'h1111_2222, 5'd9, 32'h0);
        @(negedge clk);
        // A competing instruction is presented while the result is stalled.
        in_funct3 = 3'b010; in_csr_addr = 12'h123; in_rs1_idx = 5'd6; in_rd_idx = 5'd3;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (out_valid !== 1'b1 || out_rd_data !== 32'hA5A5_0001 || out_rd_idx !== 5'd9)
                begin n_fail++; $display("FAIL stall_hold[%0d]: valid=%0b data=%h idx=%0d want 1 a5a50001 9", i, out_valid, out_rd_data, out_rd_idx); end
            n_checks++; if (in_ready !== 1'b0 || csr_addr !== 12'h340)
                begin n_fail++; $display("FAIL stall_ignore[%0d]: in_ready=%0b addr=%h want 0 340", i, in_ready, csr_addr); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release: in_ready=%0b valid=%0b want 1 0", in_ready, out_valid); end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (csr_addr !== 12'h123) begin n_fail++; $display("FAIL stall_next_accept: got %h want 123", csr_addr); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int wen_seen = 0;
        csr_rdata = 32'h0;
        send(3'b001, 1'b0, 1'b0, 12'h305, 5'd1, 32'h55, 5'd1, 32'h0);
        rst = 1'b0;
        #1;
        n_checks++; if (csr_wen !== 1'b0 || csr_addr !== 12'h0) begin n_fail++; $display("FAIL midrst_exec: wen=%0b addr=%h want 0 0", csr_wen, csr_addr); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) rst = 1'b1;
            if (csr_wen || csr_is_ecall || out_valid) wen_seen++;
        end
        n_checks++; if (wen_seen !== 0) begin n_fail++; $display("FAIL midrst_no_pulse: got %0d want 0", wen_seen); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %0b want 1", in_ready); end
        out_ready = 1'b0;
        csr_rdata = 32'h77;
        send(3'b001, 1'b0, 1'b0, 12'h305, 5'd1, 32'h55, 5'd1, 32'h0);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_resp_pre: got %0b want 1", out_valid); end
        rst = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_rd_data !== 32'h0) begin n_fail++; $display("FAIL midrst_resp: valid=%0b data=%h want 0 0", out_valid, out_rd_data); end
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_illegal();
        csr_rdata = 32'h42;
        send(3'b100, 1'b0, 1'b0, 12'h300, 5'd5, 32'hF, 5'd4, 32'h0);
        n_checks++; if (csr_wen !== 1'b0 || csr_is_ecall !== 1'b0) begin n_fail++; $display("FAIL ill_strobes: wen=%0b ecall=%0b want 0 0", csr_wen, csr_is_ecall); end
        @(negedge clk);
        n_checks++; if (out_illegal !== 1'b1) begin n_fail++; $display("FAIL ill_flag: got %0b want 1", out_illegal); end
        n_checks++; if (out_rd_wen !== 1'b0 || out_redirect !== 1'b0) begin n_fail++; $display("FAIL ill_side: rd_wen=%0b redirect=%0b want 0 0", out_rd_wen, out_redirect); end
        @(negedge clk);
    endtask

    initial begin
        in_valid = 1'b0; in_funct3 = '0; in_is_ecall = 1'b0; in_is_mret = 1'b0;
        in_csr_addr = '0; in_rs1_idx = '0; in_rs1_data = '0; in_rd_idx = '0; in_pc = '0;
        csr_rdata = '0; csr_mtvec = '0; csr_mepc = '0; out_ready = 1'b1;
        test_reset();
        test_csrrw();
        test_csrrs();
        test_imm();
        test_ecall_mret();
        test_stall();
        test_reset_mid();
        test_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
